mem_bus_ctrl: RTL and testbench

Synchronous bus sequencer between the processor core's load/store path and the asynchronous, tristate-data `RAM` block. It accepts single-word read/write requests on a simple request/acknowledge interface. It generates registered `ADDR`/`CS_n`/`OE`/`WS` strobes with setup and hold cycles around the `WS` rising edge, and owns the controller side of the shared bidirectional `DATA` bus.

---
 rtl/mem_bus_if.sv | 28 ++
 rtl/mem_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// Core-side request/acknowledge signals and RAM-side strobes of the memory bus sequencer.
// The shared tristate DATA bus stays a plain inout port on the controller.
interface mem_bus_if #(
   parameter int Depth = 5,
   parameter int Width = 8
);
   logic             REQ;
   logic             WE;
   logic [Depth-1:0] A;
   logic [Width-1:0] WDATA;
   logic [Width-1:0] RDATA;
   logic             ACK;
   logic             BUSY;
   logic [Depth-1:0] ADDR;
   logic             CS_n;
   logic             OE;
   logic             WS;

   modport slave (
      input  REQ, WE, A, WDATA,
      output RDATA, ACK, BUSY, ADDR, CS_n, OE, WS
   );

   modport master (
      output REQ, WE, A, WDATA,
      input  RDATA, ACK, BUSY, ADDR, CS_n, OE, WS
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-word read/write sequencer for an asynchronous tristate-data RAM.
// Every strobe is registered from the next state so no input reaches an output combinationally.
module mem_bus_ctrl #(
   parameter int Depth = 5,
   parameter int Width = 8
) (
   input  logic             CLK,
   input  logic             RST_n,
   mem_bus_if.slave         bus,
   inout  wire  [Width-1:0] DATA
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WSU  = 3'd2,
      WST  = 3'd3,
      WHD  = 3'd4,
      ACKS = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic             accept;
   logic [Depth-1:0] addr_q, addr_d;
   logic [Width-1:0] wdata_q, wdata_d;
   logic [Width-1:0] rdata_q, rdata_d;
   logic             we_q, we_d;
   logic             cs_n_q, cs_n_d;
   logic             oe_q, oe_d;
   logic             ws_q, ws_d;
   logic             drive_q, drive_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;

   // State register
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.REQ) begin
               state_d = bus.WE ? WSU : RD;
            end else begin
               state_d = IDLE;
            end
         end
         RD:      state_d = ACKS;
         WSU:     state_d = WST;
         WST:     state_d = WHD;
         WHD:     state_d = ACKS;
         ACKS:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch and read capture; request inputs are only looked at in IDLE
   always_comb begin
      accept  = (state_q == IDLE) && bus.REQ;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d  = bus.A;
         wdata_d = bus.WDATA;
         we_d    = bus.WE;
      end else begin
         addr_d  = addr_q;
         wdata_d = wdata_q;
         we_d    = we_q;
      end
      if ((state_q == RD) && !we_q) begin
         rdata_d = DATA;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Strobe decode from the next state; the data driver is also gated by the latched op
   always_comb begin
      cs_n_d  = 1'b1;
      oe_d    = 1'b0;
      ws_d    = 1'b0;
      drive_d = 1'b0;
      ack_d   = 1'b0;
      busy_d  = (state_d != IDLE);
      case (state_d)
         IDLE: begin
            cs_n_d = 1'b1;
         end
         RD: begin
            cs_n_d = 1'b0;
            oe_d   = 1'b1;
         end
         WSU: begin
            cs_n_d  = 1'b0;
            drive_d = we_d;
         end
         WST: begin
            cs_n_d  = 1'b0;
            ws_d    = 1'b1;
            drive_d = we_d;
         end
         WHD: begin
            cs_n_d  = 1'b0;
            drive_d = we_d;
         end
         ACKS: begin
            ack_d = 1'b1;
         end
         default: begin
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         addr_q  <= {Depth{1'b0}};
         wdata_q <= {Width{1'b0}};
         we_q    <= 1'b0;
         rdata_q <= {Width{1'b0}};
         cs_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         ws_q    <= 1'b0;
         drive_q <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         cs_n_q  <= cs_n_d;
         oe_q    <= oe_d;
         ws_q    <= ws_d;
         drive_q <= drive_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   assign DATA      = drive_q ? wdata_q : {Width{1'bz}};
   assign bus.ADDR  = addr_q;
   assign bus.CS_n  = cs_n_q;
   assign bus.OE    = oe_q;
   assign bus.WS    = ws_q;
   assign bus.RDATA = rdata_q;
   assign bus.ACK   = ack_q;
   assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a behavioural asynchronous RAM on the shared DATA bus.
module tb_mem_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       probe_en;
   wire  [7:0] data_w;
   logic [7:0] mem [32];
   int         n_checks = 0;
   int         n_fail   = 0;

   mem_bus_if #(.Depth(5), .Width(8)) bus ();

   mem_bus_ctrl #(.Depth(5), .Width(8)) dut (
      .CLK   (clk),
      .RST_n (rst_n),
      .bus   (bus.slave),
      .DATA  (data_w)
   );

   always #5 clk = ~clk;

   // RAM drives on CS_n=0 & OE=1; the probe pulls the bus low only to prove nobody else drives it
   assign data_w = (!bus.CS_n && bus.OE) ? mem[bus.ADDR] : 8'hzz;
   assign data_w = probe_en ? 8'h00 : 8'hzz;

   // RAM storage: word i starts as 0x80|i and is written on the WS rising edge
   always begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h80 | 8'(i);
      forever begin
         @(posedge bus.WS);
         mem[bus.ADDR] = data_w;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_undriven(input string tag);
      probe_en = 1'b1;
      #1;
      chk(tag, {24'h0, data_w}, 32'h0);
      probe_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [7:0] d, input logic hold,
                           input logic [4:0] a_mid, input logic [7:0] d_mid);
      bus.REQ = 1'b1; bus.WE = 1'b1; bus.A = a; bus.WDATA = d;
      tick();
      bus.REQ = hold; bus.WE = 1'b0; bus.A = a_mid; bus.WDATA = d_mid;
      chk("wsu_cs_n", bus.CS_n, 1'b0);
      chk("wsu_oe",   bus.OE,   1'b0);
      chk("wsu_ws",   bus.WS,   1'b0);
      chk("wsu_addr", bus.ADDR, a);
      chk("wsu_data", data_w,   d);
      chk("wsu_busy", bus.BUSY, 1'b1);
      tick();
      chk("wst_ws",   bus.WS,   1'b1);
      chk("wst_cs_n", bus.CS_n, 1'b0);
      chk("wst_addr", bus.ADDR, a);
      chk("wst_data", data_w,   d);
      chk("wst_ack",  bus.ACK,  1'b0);
      tick();
      chk("whd_ws",   bus.WS,   1'b0);
      chk("whd_cs_n", bus.CS_n, 1'b0);
      chk("whd_addr", bus.ADDR, a);
      chk("whd_data", data_w,   d);
      chk("whd_ack",  bus.ACK,  1'b0);
      tick();
      chk("wack_ack",  bus.ACK,  1'b1);
      chk("wack_cs_n", bus.CS_n, 1'b1);
      chk("wack_busy", bus.BUSY, 1'b1);
      chk("wack_addr", bus.ADDR, a);
      chk_undriven("wack_data_z");
      tick();
      chk("widle_ack",  bus.ACK,  1'b0);
      chk("widle_busy", bus.BUSY, 1'b0);
      chk("widle_addr", bus.ADDR, a);
      if (!hold) chk_undriven("widle_data_z");
   endtask

   task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input logic hold);
      bus.REQ = 1'b1; bus.WE = 1'b0; bus.A = a;
      tick();
      bus.REQ = hold; bus.WE = 1'b1; bus.A = ~a;
      chk("rd_cs_n", bus.CS_n, 1'b0);
      chk("rd_oe",   bus.OE,   1'b1);
      chk("rd_ws",   bus.WS,   1'b0);
      chk("rd_addr", bus.ADDR, a);
      chk("rd_data", data_w,   exp);
      chk("rd_busy", bus.BUSY, 1'b1);
      tick();
      chk("rack_ack",   bus.ACK,   1'b1);
      chk("rack_rdata", bus.RDATA, exp);
      chk("rack_oe",    bus.OE,    1'b0);
      chk("rack_cs_n",  bus.CS_n,  1'b1);
      tick();
      chk("ridle_ack",   bus.ACK,   1'b0);
      chk("ridle_busy",  bus.BUSY,  1'b0);
      chk("ridle_rdata", bus.RDATA, exp);
   endtask

   initial begin
      rst_n = 1'b0; probe_en = 1'b0;
      bus.REQ = 1'b1; bus.WE = 1'b1; bus.A = 5'd3; bus.WDATA = 8'hA5;
      @(posedge clk);
      tick();
      chk("rst_cs_n",  bus.CS_n,  1'b1);
      chk("rst_oe",    bus.OE,    1'b0);
      chk("rst_ws",    bus.WS,    1'b0);
      chk("rst_ack",   bus.ACK,   1'b0);
      chk("rst_busy",  bus.BUSY,  1'b0);
      chk("rst_rdata", bus.RDATA, 8'h00);
      chk("rst_addr",  bus.ADDR,  5'd0);
      chk_undriven("rst_data_z");
      rst_n = 1'b1; bus.REQ = 1'b0;
      tick();
      chk("post_rst_busy", bus.BUSY, 1'b0);

      // Write then read
      do_write(5'd3, 8'hA5, 1'b0, 5'd3, 8'hA5);
      do_read(5'd3, 8'hA5, 1'b0);

      // Address boundaries
      do_write(5'd0,  8'h11, 1'b0, 5'd0,  8'h11);
      do_write(5'd31, 8'hEE, 1'b0, 5'd31, 8'hEE);
      do_read(5'd0,  8'h11, 1'b0);
      do_read(5'd31, 8'hEE, 1'b0);

      // Back-to-back with REQ held high
      do_write(5'd5, 8'h3C, 1'b1, 5'd5, 8'h3C);
      do_read(5'd5, 8'h3C, 1'b1);
      do_write(5'd5, 8'hC3, 1'b1, 5'd5, 8'hC3);
      do_read(5'd5, 8'hC3, 1'b0);

      // Inputs changed mid-transaction are ignored
      do_write(5'd7, 8'h42, 1'b0, 5'd9, 8'hFF);
      do_read(5'd7, 8'h42, 1'b0);
      do_read(5'd9, 8'h89, 1'b0);

      // Reset while in the write-strobe state
      bus.REQ = 1'b1; bus.WE = 1'b1; bus.A = 5'd12; bus.WDATA = 8'h77;
      tick();
      bus.REQ = 1'b0;
      tick();
      chk("mrst_pre_ws", bus.WS, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("mrst_cs_n",  bus.CS_n,  1'b1);
      chk("mrst_oe",    bus.OE,    1'b0);
      chk("mrst_ws",    bus.WS,    1'b0);
      chk("mrst_busy",  bus.BUSY,  1'b0);
      chk("mrst_ack",   bus.ACK,   1'b0);
      chk("mrst_addr",  bus.ADDR,  5'd0);
      chk("mrst_rdata", bus.RDATA, 8'h00);
      chk_undriven("mrst_data_z");
      rst_n = 1'b1;
      tick();
      chk("mrst_ack2",  bus.ACK,  1'b0);
      chk("mrst_busy2", bus.BUSY, 1'b0);
      do_read(5'd2, 8'h82, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
